// File: rtl/addsub_pipe_hs.sv
// -----------------------------------------------------------------------------
// addsub_pipe_hs
//   Handshaked add/subtract pipeline. Both operands and the op code are taken
//   in the same accept cycle. The result and its overflow flag are computed at
//   accept and carried through DEPTH valid-tagged stages. The last stage drives
//   the output. A saturating counter tallies consumed overflow beats.
//
// Parameters
//   W       operand/result width (>= 2)
//   DEPTH   stages = accept-to-output latency in cycles (1..8)
//   SIGNED  0: unsigned arithmetic, 1: two's-complement
//   CW      width of ovf_cnt
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b [W]      operands
//   in_op [2]           00 add-wrap, 01 sub-wrap (A-B), 10 add-sat, 11 sub-sat
//   out_valid/out_ready result handshake
//   out_y [W]           result
//   out_ovf             wrap: true result out of range; sat: result clamped
//   ovf_cnt_clr         synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt [CW]        consumed beats with out_ovf=1, saturates at all-ones
//
// Handshake: a beat moves only on a cycle where valid && ready are both high
// at the rising edge. A producer holding valid keeps its data stable until it
// is taken. out_y/out_ovf do not change while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module addsub_pipe_hs #(
  parameter int W      = 10,
  parameter int DEPTH  = 2,
  parameter int SIGNED = 0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic          out_ovf,
  input  logic          ovf_cnt_clr,
  output logic [CW-1:0] ovf_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     y_q   [DEPTH];
  logic             ovf_q [DEPTH];

  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_vld;
  logic [W-1:0]     src_y   [DEPTH];
  logic             src_ovf [DEPTH];

  logic [W:0]       ext_a;
  logic [W:0]       ext_b;
  logic [W:0]       raw;
  logic             raw_ovf;
  logic [W-1:0]     sat_y;
  logic [W-1:0]     res_y;

  // Arithmetic is done once, at accept, in W+1 bits.
  always_comb begin
    if (SIGNED != 0) begin
      ext_a = {in_a[W-1], in_a};
      ext_b = {in_b[W-1], in_b};
    end else begin
      ext_a = {1'b0, in_a};
      ext_b = {1'b0, in_b};
    end
    raw = in_op[0] ? (ext_a - ext_b) : (ext_a + ext_b);
    if (SIGNED != 0) begin
      // Signed result leaves the W-bit range when the two top bits disagree;
      // the extra top bit is then the true sign and picks the nearer bound.
      raw_ovf = raw[W] ^ raw[W-1];
      sat_y   = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      // Top bit is carry for add, borrow (A<B) for sub.
      raw_ovf = raw[W];
      sat_y   = in_op[0] ? {W{1'b0}} : {W{1'b1}};
    end
    res_y = (in_op[1] && raw_ovf) ? sat_y : raw[W-1:0];
  end

  // A stage may load when it is empty or its content moves on. Unrolled from
  // the output end: stage k can load if out_ready is high or any stage at or
  // after k is empty, which lets bubbles collapse.
  always_comb begin
    logic hole;
    hole = 1'b0;
    load = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole    = hole | ~vld[k];
      load[k] = hole | out_ready;
    end
  end

  assign in_ready = load[0];

  // Source of each stage: the accept logic for stage 0, the previous stage
  // otherwise.
  always_comb begin
    src_vld[0] = in_valid;
    src_y[0]   = res_y;
    src_ovf[0] = raw_ovf;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld[k-1];
      src_y[k]   = y_q[k-1];
      src_ovf[k] = ovf_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        y_q[k]   <= '0;
        ovf_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          vld[k] <= src_vld[k];
          // Data only moves with a valid beat so an idle stage keeps its value.
          if (src_vld[k]) begin
            y_q[k]   <= src_y[k];
            ovf_q[k] <= src_ovf[k];
          end
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_y     = y_q[DEPTH-1];
  assign out_ovf   = ovf_q[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CW'(1);
    end
  end

endmodule
